// File: rtl/exe_divider.sv
// Iterative RV64M divider for the execute stage: DIV/DIVU/REM/REMU and *W variants.
// Restoring radix-2, one quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module exe_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic            word_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  // Handshake: start_i is accepted only in IDLE (and never alongside flush_i); the op then
  // owns the unit until done_o pulses for one cycle with result_o valid. stall_req_o holds
  // the pipeline from the accepting cycle until DONE, where it drops so the pipe advances.

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_WORD = CW'(31);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_d;

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] div_q;
  logic [CW-1:0]   cnt_q;
  logic            sign_q_q;
  logic            sign_r_q;
  logic            rem_op_q;
  logic            word_op_q;
  logic [XLEN-1:0] result_q;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  // Operand preparation and special-case detection, evaluated from the live inputs in IDLE.
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_n, spec_val;
  logic            a_neg, b_neg, div_zero, ovf, special, accept;

  always_comb begin
    a_ext = rs1_data_i;
    b_ext = rs2_data_i;
    if (word_i) begin
      a_ext = signed_i ? sext_w(rs1_data_i) : {{(XLEN-32){1'b0}}, rs1_data_i[31:0]};
      b_ext = signed_i ? sext_w(rs2_data_i) : {{(XLEN-32){1'b0}}, rs2_data_i[31:0]};
    end
    a_neg    = signed_i & (word_i ? rs1_data_i[31] : rs1_data_i[XLEN-1]);
    b_neg    = signed_i & (word_i ? rs2_data_i[31] : rs2_data_i[XLEN-1]);
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    min_n    = word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = signed_i & (a_ext == min_n) & (&b_ext);
    special  = div_zero | ovf;
    if (div_zero) begin
      spec_val = rem_i ? a_ext : '1;
    end else begin
      spec_val = rem_i ? '0 : a_ext;
    end
    if (word_i) begin
      spec_val = sext_w(spec_val);
    end
    accept = (state == IDLE) & start_i & ~flush_i;
  end

  // One restoring step: shift the next dividend bit in, keep the trial difference if non-negative.
  logic [XLEN:0]   shifted, trial;
  logic            q_bit;
  logic [XLEN-1:0] q_fix, r_fix, fix_val;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, div_q};
    q_bit   = ~trial[XLEN];
    q_fix   = sign_q_q ? -quo_q : quo_q;
    r_fix   = sign_r_q ? -rem_q : rem_q;
    fix_val = rem_op_q ? r_fix : q_fix;
    if (word_op_q) begin
      fix_val = sext_w(fix_val);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      rem_op_q  <= 1'b0;
      word_op_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      // Word ops park the 32-bit dividend in the top half so MSB-first shifting still works.
      quo_q     <= word_i ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
      rem_q     <= '0;
      div_q     <= b_abs;
      cnt_q     <= word_i ? CNT_WORD : CNT_FULL;
      sign_q_q  <= a_neg ^ b_neg;
      sign_r_q  <= a_neg;
      rem_op_q  <= rem_i;
      word_op_q <= word_i;
      if (special) begin
        result_q <= spec_val;
      end
    end else if (!flush_i) begin
      if (state == CALC) begin
        rem_q <= q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], q_bit};
        cnt_q <= cnt_q - 1'b1;
      end else if (state == FIX) begin
        result_q <= fix_val;
      end
    end
  end

  assign stall_req_o = ~flush_i & (((state == IDLE) & start_i) | (state == CALC) | (state == FIX));
  assign done_o      = ~flush_i & (state == DONE);
  assign busy_o      = (state != IDLE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_exe_divider.sv
// Directed bench for exe_divider: quotient/remainder values, latency, stall window,
// special cases, word-mode sign extension, flush, ignored start and mid-op reset.
module tb_exe_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, rem_i, word_i, flush_i;
  logic [63:0] rs1_data_i, rs2_data_i;
  logic        stall_req_o, done_o, busy_o;
  logic [63:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

  exe_divider #(.XLEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .rem_i       (rem_i),
    .word_i      (word_i),
    .flush_i     (flush_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .stall_req_o (stall_req_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; drives the op with start_i for exactly this cycle (T).
  task automatic start_op(input logic s, input logic r, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
    signed_i   = s;
    rem_i      = r;
    word_i     = w;
    rs1_data_i = a;
    rs2_data_i = b;
    start_i    = 1'b1;
    #1;
    check("stall_at_start", {63'b0, stall_req_o}, 64'd1);
  endtask

  // Walks cycles T+1.. until done_o; optionally pulses a bogus start at cycle T+pulse_k.
  task automatic wait_result(input string tag, input logic [63:0] exp, input int exp_lat,
                             input int pulse_k);
    int lat;
    int gap;
    lat = -1;
    gap = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == pulse_k) begin
        start_i    = 1'b1;
        signed_i   = 1'b1;
        rem_i      = 1'b1;
        rs1_data_i = 64'd200;
        rs2_data_i = 64'd3;
      end else begin
        start_i = 1'b0;
      end
      #1;
      if (done_o) begin
        lat = k;
        break;
      end
      if (!stall_req_o) gap++;
    end
    start_i = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check(tag, result_o, exp);
    check({tag, "_stall_gap"}, 64'(gap), 64'd0);
    check({tag, "_stall_at_done"}, {63'b0, stall_req_o}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic s, input logic r, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    @(negedge clk);
    check({tag, "_pre_done"}, {63'b0, done_o}, 64'd0);
    check({tag, "_pre_busy"}, {63'b0, busy_o}, 64'd0);
    start_op(s, r, w, a, b);
    wait_result(tag, exp, exp_lat, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0; word_i = 1'b0;
    flush_i = 1'b0; rs1_data_i = '0; rs2_data_i = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", {63'b0, stall_req_o}, 64'd0);
    check("rst_done", {63'b0, done_o}, 64'd0);
    check("rst_busy", {63'b0, busy_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    rst = 1'b0;

    // Unsigned and signed 64-bit division, back-to-back starts.
    run_op("divu_100_7", 0, 0, 0, 64'd100, 64'd7, 64'd14, 66);
    run_op("remu_100_7", 0, 1, 0, 64'd100, 64'd7, 64'd2, 66);
    run_op("div_m7_2", 1, 0, 0, -64'sd7, 64'd2, -64'sd3, 66);
    run_op("rem_m7_2", 1, 1, 0, -64'sd7, 64'd2, -64'sd1, 66);
    run_op("rem_7_m2", 1, 1, 0, 64'd7, -64'sd2, 64'd1, 66);
    run_op("div_m100_m7", 1, 0, 0, -64'sd100, -64'sd7, 64'd14, 66);
    run_op("divu_max_3", 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 66);

    // Special cases resolve in one cycle.
    run_op("divu_by0", 0, 0, 0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem_5_by0", 1, 1, 0, 64'd5, 64'd0, 64'd5, 1);
    run_op("div_ovf", 1, 0, 0, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 1, 1, 0, 64'h8000_0000_0000_0000, -64'sd1, 64'd0, 1);

    // Word variants.
    run_op("divw_ovf", 1, 0, 1, 64'h1_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("divuw_fffe_1", 0, 0, 1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run_op("divuw_8000_1", 0, 0, 1, 64'hABCD_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34);
    run_op("remw_m7_2", 1, 1, 1, 64'h1234_5678_FFFF_FFF9, 64'hFFFF_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("remuw_mod16", 0, 1, 1, 64'h8000_0007, 64'd16, 64'd7, 34);

    // Flush at T+20 aborts; a fresh op at T+21 completes normally.
    @(negedge clk);
    start_op(0, 0, 0, 64'd100, 64'd7);
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      if (done_o) dones++;
    end
    flush_i = 1'b1;
    #1;
    check("flush_stall", {63'b0, stall_req_o}, 64'd0);
    check("flush_done", {63'b0, done_o}, 64'd0);
    check("flush_no_done_before", 64'(dones), 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_idle", {63'b0, busy_o}, 64'd0);
    start_op(0, 0, 0, 64'd1000, 64'd9);
    wait_result("after_flush", 64'd111, 66, 0);

    // Start together with flush is dropped.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; rs1_data_i = 64'd50; rs2_data_i = 64'd5;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("start_with_flush_dropped", {63'b0, busy_o}, 64'd0);

    // A start pulsed during CALC must not disturb the running op.
    @(negedge clk);
    start_op(0, 0, 0, 64'd100, 64'd7);
    wait_result("start_in_calc", 64'd14, 66, 10);

    // Reset at T+10 clears every output at T+11 and suppresses done_o.
    @(negedge clk);
    start_op(0, 1, 0, 64'd100, 64'd7);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_stall", {63'b0, stall_req_o}, 64'd0);
    check("midrst_done", {63'b0, done_o}, 64'd0);
    check("midrst_busy", {63'b0, busy_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #1;
      if (done_o) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
